// File: rtl/capi_putn_cmd_enc_pkg.sv
// Shared types for the PSL put-command encoder: size-select codes, FSM states,
// and the command entry that is queued toward the PSL.
package capi_putn_pkg;
  localparam int TSIZE_W = 13;
  // Widest supported field widths; the top slices these down to its parameters.
  localparam int EA_W   = 64;
  localparam int TAG_W  = 5;
  localparam int CTXT_W = 10;

  localparam logic [1:0] SEL_128 = 2'd0;
  localparam logic [1:0] SEL_256 = 2'd1;
  localparam logic [1:0] SEL_512 = 2'd2;
  localparam logic [1:0] SEL_MAX = 2'd3;

  typedef enum logic [0:0] {ST_IDLE, ST_STREAM} state_t;

  typedef struct packed {
    logic [EA_W-1:0]    ea;
    logic [TSIZE_W-1:0] tsize;
    logic [TAG_W-1:0]   tag;
    logic [CTXT_W-1:0]  ctxt;
    logic               last;
  } cmd_entry_t;

  // Command size for a select code, never larger than the supported cap.
  function automatic logic [TSIZE_W-1:0] sel_bytes(input logic [1:0] sel, input int cap);
    int b;
    case (sel)
      SEL_128: b = 128;
      SEL_256: b = 256;
      SEL_512: b = 512;
      default: b = cap;
    endcase
    if (b > cap) b = cap;
    return TSIZE_W'(b);
  endfunction
endpackage

// File: rtl/capi_putn_cmd_enc_if.sv
// Request / data / downstream / command bus of the put-command encoder.
interface capi_putn_cmd_enc_if import capi_putn_pkg::*; #(
    parameter int ea_width   = 64,
    parameter int beat_bytes = 16,
    parameter int tag_width  = 5,
    parameter int ctxt_width = 10,
    parameter int fifo_depth = 8
) ();
    logic [1:0]                    i_cfg_max_sel;
    logic                          i_req_v;
    logic                          o_req_r;
    logic [ea_width-1:0]           i_req_ea;
    logic [tag_width-1:0]          i_req_tag;
    logic [ctxt_width-1:0]         i_req_ctxt;
    logic                          i_data_v;
    logic                          o_data_r;
    logic                          i_data_e;
    logic [$clog2(beat_bytes)-1:0] i_data_c;
    logic                          o_dn_data_v;
    logic                          i_dn_data_r;
    logic                          o_dn_cmd_e;
    logic                          o_dn_req_e;
    logic                          o_cmd_v;
    logic                          i_cmd_r;
    logic [ea_width-1:0]           o_cmd_ea;
    logic [TSIZE_W-1:0]            o_cmd_tsize;
    logic [tag_width-1:0]          o_cmd_tag;
    logic [ctxt_width-1:0]         o_cmd_ctxt;
    logic                          o_cmd_last;
    logic                          o_req_err;
    logic [$clog2(fifo_depth):0]   o_cmd_used;

    modport master (
        output i_cfg_max_sel, i_req_v, i_req_ea, i_req_tag, i_req_ctxt,
               i_data_v, i_data_e, i_data_c, i_dn_data_r, i_cmd_r,
        input  o_req_r, o_data_r, o_dn_data_v, o_dn_cmd_e, o_dn_req_e,
               o_cmd_v, o_cmd_ea, o_cmd_tsize, o_cmd_tag, o_cmd_ctxt,
               o_cmd_last, o_req_err, o_cmd_used
    );

    modport slave (
        input  i_cfg_max_sel, i_req_v, i_req_ea, i_req_tag, i_req_ctxt,
               i_data_v, i_data_e, i_data_c, i_dn_data_r, i_cmd_r,
        output o_req_r, o_data_r, o_dn_data_v, o_dn_cmd_e, o_dn_req_e,
               o_cmd_v, o_cmd_ea, o_cmd_tsize, o_cmd_tag, o_cmd_ctxt,
               o_cmd_last, o_req_err, o_cmd_used
    );
endinterface

// File: rtl/capi_putn_cmd_enc_fifo.sv
// Shared show-ahead FIFO; head word is valid combinationally while o_v is high.
module nvme_fifo #(
    parameter int width = 8,
    parameter int words = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [width-1:0]           i_din,
    input  logic                       i_pop,
    output logic [width-1:0]           o_dout,
    output logic                       o_v,
    output logic                       o_full,
    output logic [$clog2(words):0]     o_used
);
    localparam int AW = $clog2(words);

    logic [width-1:0] mem [words];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      used_q;
    logic             do_push, do_pop;

    assign o_full  = used_q == (AW+1)'(words);
    assign o_v     = used_q != '0;
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & o_v;
    assign o_dout  = mem[rd_q];
    assign o_used  = used_q;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= i_din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            used_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            used_q <= used_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/capi_putn_cmd_enc.sv
// Cuts one write request's beat stream into PSL put commands bounded by the
// selected max size (and therefore by pages), queueing them in a command FIFO.
module capi_putn_cmd_enc import capi_putn_pkg::*; #(
    parameter int ea_width   = 64,
    parameter int beat_bytes = 16,
    parameter int max_bytes  = 512,
    parameter int page_bytes = 4096,
    parameter int tag_width  = 5,
    parameter int ctxt_width = 10,
    parameter int fifo_depth = 8
) (
    input  logic              clk,
    input  logic              reset,
    capi_putn_cmd_enc_if.slave bus
);
    localparam int BB_W   = $clog2(beat_bytes);
    localparam int USED_W = $clog2(fifo_depth) + 1;
    localparam int CTXT_O = 1;
    localparam int TAG_O  = CTXT_O + ctxt_width;
    localparam int TS_O   = TAG_O + tag_width;
    localparam int EA_O   = TS_O + TSIZE_W;
    localparam int FW     = EA_O + ea_width;
    localparam int CAP    = (max_bytes < page_bytes) ? max_bytes : page_bytes;
    localparam logic [TSIZE_W-1:0] BEAT = TSIZE_W'(beat_bytes);

    state_t                state_q, state_d;
    logic [ea_width-1:0]   cmd_ea_q, cmd_ea_d;
    logic [TSIZE_W-1:0]    len_q, len_d, size_q, size_d;
    logic [tag_width-1:0]  tag_q, tag_d;
    logic [ctxt_width-1:0] ctxt_q, ctxt_d;
    logic                  req_r_q, err_q, err_d;
    logic                  stream, go, push, cmd_end, bnd_end, dn_v;
    logic                  fifo_full, fifo_v;
    logic [TSIZE_W-1:0]    last_b, beat_b, tsize_push, off;
    logic [USED_W-1:0]     fifo_used;
    logic [FW-1:0]         fifo_din, fifo_dout;
    cmd_entry_t            push_ent, head_ent;

    assign stream     = state_q == ST_STREAM;
    assign last_b     = (bus.i_data_c == '0) ? BEAT : TSIZE_W'(bus.i_data_c);
    assign beat_b     = bus.i_data_e ? last_b : BEAT;
    assign tsize_push = len_q + beat_b;
    // Boundary test only needs the low address bits since size divides 2^TSIZE_W.
    assign off        = cmd_ea_q[TSIZE_W-1:0] + len_q + BEAT;
    assign bnd_end    = (off & (size_q - TSIZE_W'(1))) == '0;
    assign cmd_end    = bus.i_data_e | bnd_end;
    assign dn_v       = stream & bus.i_data_v & ~fifo_full;
    assign go         = dn_v & bus.i_dn_data_r;

    assign bus.o_req_r     = req_r_q;
    assign bus.o_req_err   = err_q;
    assign bus.o_data_r    = stream & bus.i_dn_data_r & ~fifo_full;
    assign bus.o_dn_data_v = dn_v;
    assign bus.o_dn_cmd_e  = dn_v & cmd_end;
    assign bus.o_dn_req_e  = dn_v & bus.i_data_e;

    always_comb begin
        state_d  = state_q;
        cmd_ea_d = cmd_ea_q;
        len_d    = len_q;
        size_d   = size_q;
        tag_d    = tag_q;
        ctxt_d   = ctxt_q;
        err_d    = 1'b0;
        push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_req_v) begin
                    cmd_ea_d = {bus.i_req_ea[ea_width-1:BB_W], {BB_W{1'b0}}};
                    len_d    = '0;
                    size_d   = sel_bytes(bus.i_cfg_max_sel, CAP);
                    tag_d    = bus.i_req_tag;
                    ctxt_d   = bus.i_req_ctxt;
                    err_d    = |bus.i_req_ea[BB_W-1:0];
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (go) begin
                    if (cmd_end) begin
                        push     = 1'b1;
                        cmd_ea_d = cmd_ea_q + ea_width'(tsize_push);
                        len_d    = '0;
                        if (bus.i_data_e) state_d = ST_IDLE;
                    end else begin
                        len_d = len_q + BEAT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cmd_ea_q <= '0;
            len_q    <= '0;
            size_q   <= '0;
            tag_q    <= '0;
            ctxt_q   <= '0;
            req_r_q  <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_ea_q <= cmd_ea_d;
            len_q    <= len_d;
            size_q   <= size_d;
            tag_q    <= tag_d;
            ctxt_q   <= ctxt_d;
            req_r_q  <= state_d == ST_IDLE;
            err_q    <= err_d;
        end
    end

    always_comb begin
        push_ent       = '0;
        push_ent.ea    = EA_W'(cmd_ea_q);
        push_ent.tsize = tsize_push;
        push_ent.tag   = TAG_W'(tag_q);
        push_ent.ctxt  = CTXT_W'(ctxt_q);
        push_ent.last  = bus.i_data_e;
    end

    assign fifo_din = {push_ent.ea[ea_width-1:0], push_ent.tsize,
                       push_ent.tag[tag_width-1:0], push_ent.ctxt[ctxt_width-1:0],
                       push_ent.last};

    nvme_fifo #(.width(FW), .words(fifo_depth)) u_cmd_fifo (
        .clk    (clk),
        .reset  (reset),
        .i_push (push),
        .i_din  (fifo_din),
        .i_pop  (bus.i_cmd_r),
        .o_dout (fifo_dout),
        .o_v    (fifo_v),
        .o_full (fifo_full),
        .o_used (fifo_used)
    );

    // Head fields are forced to zero while the queue is empty.
    always_comb begin
        head_ent = '0;
        if (fifo_v) begin
            head_ent.ea    = EA_W'(fifo_dout[EA_O +: ea_width]);
            head_ent.tsize = fifo_dout[TS_O +: TSIZE_W];
            head_ent.tag   = TAG_W'(fifo_dout[TAG_O +: tag_width]);
            head_ent.ctxt  = CTXT_W'(fifo_dout[CTXT_O +: ctxt_width]);
            head_ent.last  = fifo_dout[0];
        end
    end

    assign bus.o_cmd_v     = fifo_v;
    assign bus.o_cmd_ea    = head_ent.ea[ea_width-1:0];
    assign bus.o_cmd_tsize = head_ent.tsize;
    assign bus.o_cmd_tag   = head_ent.tag[tag_width-1:0];
    assign bus.o_cmd_ctxt  = head_ent.ctxt[ctxt_width-1:0];
    assign bus.o_cmd_last  = head_ent.last;
    assign bus.o_cmd_used  = fifo_used;
endmodule

// File: tb/tb_capi_putn_cmd_enc.sv
// Bench for capi_putn_cmd_enc: directed cases plus random requests against a
// byte-range splitting model of the command stream.
module tb_capi_putn_cmd_enc;
    localparam int DEPTH = 4;
    localparam int MAXB  = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    capi_putn_cmd_enc_if #(.fifo_depth(DEPTH)) bus ();

    capi_putn_cmd_enc #(.max_bytes(MAXB), .fifo_depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] ea;
        int          tsize;
        logic [4:0]  tag;
        logic [9:0]  ctxt;
        logic        last;
    } cmd_t;

    cmd_t expq[$];
    cmd_t logq[$];
    int   occ = 0;
    int   checks = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sel_size(input logic [1:0] s);
        return (s == 2'd3) ? MAXB : (128 << s);
    endfunction

    task automatic idle_inputs();
        bus.i_req_v     = 1'b0;
        bus.i_data_v    = 1'b0;
        bus.i_data_e    = 1'b0;
        bus.i_data_c    = '0;
        bus.i_dn_data_r = 1'b0;
        bus.i_cmd_r     = 1'b0;
    endtask

    // Compare the FIFO head with the oldest expected command and log what was seen.
    task automatic pop_check();
        cmd_t e, o;
        o.ea = bus.o_cmd_ea; o.tsize = int'(bus.o_cmd_tsize);
        o.tag = bus.o_cmd_tag; o.ctxt = bus.o_cmd_ctxt; o.last = bus.o_cmd_last;
        logq.push_back(o);
        if (expq.size() == 0) begin
            chk("unexpected_cmd", 64'(o.tsize), 64'(0));
        end else begin
            e = expq.pop_front();
            chk("cmd_ea", o.ea, e.ea);
            chk("cmd_tsize", 64'(o.tsize), 64'(e.tsize));
            chk("cmd_tag", 64'(o.tag), 64'(e.tag));
            chk("cmd_ctxt", 64'(o.ctxt), 64'(e.ctxt));
            chk("cmd_last", 64'(o.last), 64'(e.last));
        end
    endtask

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic run_req(input logic [63:0] ea, input logic [1:0] sel, input int nb,
                           input logic [3:0] lc, input int dn_pct, input int pop_pct,
                           input int hold, input int abort_at);
        logic [4:0]  tag;
        logic [9:0]  ctxt;
        logic [63:0] a, addr;
        logic        mis, last, cme, full, acc, pop;
        int size, rem, n, k, cyc, bytes;
        cmd_t e;
        tag  = 5'($urandom);
        ctxt = 10'($urandom);
        size = sel_size(sel);
        mis  = |ea[3:0];
        addr = ea & ~64'hF;
        // Reference: the request's byte range chopped at every multiple of size.
        a   = addr;
        rem = (nb - 1) * 16 + ((lc == 0) ? 16 : int'(lc));
        while (rem > 0) begin
            n = size - int'(a % 64'(size));
            if (n > rem) n = rem;
            e.ea = a; e.tsize = n; e.tag = tag; e.ctxt = ctxt; e.last = (n == rem);
            expq.push_back(e);
            a   = a + 64'(n);
            rem = rem - n;
        end

        #1;
        bus.i_req_v = 1'b1; bus.i_req_ea = ea; bus.i_req_tag = tag; bus.i_req_ctxt = ctxt;
        bus.i_cfg_max_sel = sel; bus.i_data_v = 1'b1; bus.i_data_e = 1'b0;
        bus.i_dn_data_r = 1'b1; bus.i_cmd_r = 1'b0;
        @(negedge clk);
        chk("req_r_idle", 64'(bus.o_req_r), 64'(1));
        chk("data_r_idle", 64'(bus.o_data_r), 64'(0));
        chk("dn_v_idle", 64'(bus.o_dn_data_v), 64'(0));
        chk("req_err_idle", 64'(bus.o_req_err), 64'(0));
        chk("used_idle", 64'(bus.o_cmd_used), 64'(occ));
        @(posedge clk);

        k = 0; cyc = 0;
        while (k < nb && k != abort_at && cyc < 4000) begin
            #1;
            last = (k == nb - 1);
            bus.i_req_v       = 1'b0;
            bus.i_cfg_max_sel = 2'($urandom);
            bus.i_data_v      = ($urandom_range(0, 99) < 80);
            bus.i_data_e      = last;
            bus.i_data_c      = last ? lc : 4'($urandom);
            bus.i_dn_data_r   = ($urandom_range(0, 99) < dn_pct);
            bus.i_cmd_r       = (cyc >= hold) && ($urandom_range(0, 99) < pop_pct);
            @(negedge clk);
            full = (occ == DEPTH);
            chk("req_r_busy", 64'(bus.o_req_r), 64'(0));
            chk("data_r", 64'(bus.o_data_r), 64'(bus.i_dn_data_r & ~full));
            chk("dn_v", 64'(bus.o_dn_data_v), 64'(bus.i_data_v & ~full));
            chk("used", 64'(bus.o_cmd_used), 64'(occ));
            chk("cmd_v", 64'(bus.o_cmd_v), 64'(occ != 0));
            chk("req_err", 64'(bus.o_req_err), 64'((cyc == 0) ? mis : 1'b0));
            bytes = last ? ((lc == 0) ? 16 : int'(lc)) : 16;
            cme   = last || (((addr + 64'd16) % 64'(size)) == 0);
            if (bus.o_dn_data_v) begin
                chk("dn_cmd_e", 64'(bus.o_dn_cmd_e), 64'(cme));
                chk("dn_req_e", 64'(bus.o_dn_req_e), 64'(last));
            end
            acc = bus.i_data_v && bus.i_dn_data_r && !full;
            pop = bus.i_cmd_r && (occ != 0);
            if (pop) pop_check();
            if (acc) begin
                addr = addr + 64'(bytes);
                k++;
                if (cme) occ++;
            end
            if (pop) occ--;
            cyc++;
            @(posedge clk);
        end
        chk("beats_taken", 64'(k), 64'((abort_at < 0) ? nb : abort_at));
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (expq.size() > 0 && cyc < 200) begin
            #1;
            idle_inputs();
            bus.i_cmd_r = 1'b1;
            @(negedge clk);
            chk("drain_cmd_v", 64'(bus.o_cmd_v), 64'(occ != 0));
            chk("drain_used", 64'(bus.o_cmd_used), 64'(occ));
            chk("drain_req_r", 64'(bus.o_req_r), 64'(1));
            chk("drain_req_err", 64'(bus.o_req_err), 64'(0));
            if (occ != 0) begin
                pop_check();
                occ--;
            end
            cyc++;
            @(posedge clk);
        end
        chk("drain_done", 64'(expq.size()), 64'(0));
        #1;
        idle_inputs();
        @(negedge clk);
        chk("empty_cmd_v", 64'(bus.o_cmd_v), 64'(0));
        chk("empty_used", 64'(bus.o_cmd_used), 64'(0));
        @(posedge clk);
    endtask

    task automatic chk_log(input int i, input logic [63:0] ea, input int ts, input logic last);
        cmd_t o;
        o.ea = '1; o.tsize = -1; o.tag = '0; o.ctxt = '0; o.last = 1'bx;
        if (i < logq.size()) o = logq[i];
        chk("log_ea", o.ea, ea);
        chk("log_tsize", 64'(o.tsize), 64'(ts));
        chk("log_last", 64'(o.last), 64'(last));
    endtask

    initial begin
        logic [63:0] rea;
        idle_inputs();
        bus.i_cfg_max_sel = '0; bus.i_req_ea = '0; bus.i_req_tag = '0; bus.i_req_ctxt = '0;
        @(negedge clk);
        chk("rst_req_r", 64'(bus.o_req_r), 64'(1));
        chk("rst_cmd_v", 64'(bus.o_cmd_v), 64'(0));
        chk("rst_used", 64'(bus.o_cmd_used), 64'(0));
        chk("rst_req_err", 64'(bus.o_req_err), 64'(0));
        chk("rst_data_r", 64'(bus.o_data_r), 64'(0));
        chk("rst_dn_v", 64'(bus.o_dn_data_v), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_r", 64'(bus.o_req_r), 64'(1));
        @(posedge clk);

        // Single command within a 512B block.
        logq.delete();
        run_req(64'h1000, 2'd2, 4, 4'd0, 100, 0, 0, -1);
        drain();
        chk("t1_count", 64'(logq.size()), 64'(1));
        chk_log(0, 64'h1000, 64, 1'b1);

        // Split at 0x1200 with a partial last beat.
        logq.delete();
        run_req(64'h11F0, 2'd2, 3, 4'd8, 100, 0, 0, -1);
        drain();
        chk("t2_count", 64'(logq.size()), 64'(2));
        chk_log(0, 64'h11F0, 16, 1'b0);
        chk_log(1, 64'h1200, 24, 1'b1);

        // 128B commands over 320 bytes.
        logq.delete();
        run_req(64'h2000, 2'd0, 20, 4'd0, 70, 0, 0, -1);
        drain();
        chk("t3_count", 64'(logq.size()), 64'(3));
        chk_log(0, 64'h2000, 128, 1'b0);
        chk_log(1, 64'h2080, 128, 1'b0);
        chk_log(2, 64'h2100, 64, 1'b1);

        // Page split with the largest command size.
        logq.delete();
        run_req(64'h3FF0, 2'd3, 2, 4'd0, 100, 0, 0, -1);
        drain();
        chk("t4_count", 64'(logq.size()), 64'(2));
        chk_log(0, 64'h3FF0, 16, 1'b0);
        chk_log(1, 64'h4000, 16, 1'b1);

        // Fill the command FIFO, then release it.
        logq.delete();
        for (int i = 0; i < 4; i++) run_req(64'h5000 + 64'(16 * i), 2'd2, 1, 4'd0, 100, 0, 0, -1);
        @(negedge clk);
        chk("full_used", 64'(bus.o_cmd_used), 64'(4));
        @(posedge clk);
        run_req(64'h5040, 2'd2, 1, 4'd0, 100, 100, 6, -1);
        drain();
        chk("t5_count", 64'(logq.size()), 64'(5));
        for (int i = 0; i < 5; i++) chk_log(i, 64'h5000 + 64'(16 * i), 16, 1'b1);

        // Misaligned start address.
        logq.delete();
        run_req(64'h1004, 2'd2, 1, 4'd0, 100, 0, 0, -1);
        drain();
        chk_log(0, 64'h1000, 16, 1'b1);

        // Reset in the middle of a stream with one command queued.
        run_req(64'h2000, 2'd0, 10, 4'd0, 100, 0, 0, 9);
        #1;
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("mid_rst_cmd_v", 64'(bus.o_cmd_v), 64'(0));
        chk("mid_rst_used", 64'(bus.o_cmd_used), 64'(0));
        chk("mid_rst_req_r", 64'(bus.o_req_r), 64'(1));
        expq.delete();
        occ = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rel_req_r", 64'(bus.o_req_r), 64'(1));
        chk("rel_cmd_v", 64'(bus.o_cmd_v), 64'(0));
        @(posedge clk);

        // Random requests with back-pressure, concurrent pops and select changes.
        for (int i = 0; i < 30; i++) begin
            rea = {32'h0, $urandom};
            if ($urandom_range(0, 9) != 0) rea[3:0] = 4'h0;
            run_req(rea, 2'($urandom), $urandom_range(1, 40), 4'($urandom), 70, 50, 0, -1);
            if (i % 10 == 9) drain();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/capi_putn_cmd_enc.md
Name: capi_putn_cmd_enc

Overview:
Parametrised put-command encoder. It takes one write request (EA, tag, context) followed by a stream of data beats of unknown length. It cuts the stream into PSL put commands that never cross a runtime-selectable max-size boundary (128/256/512/max_bytes) or a page boundary. Commands are queued in an internal FIFO, and the data beats pass through with a per-beat command-end marker.

Parameters:
ea_width, 64, effective address width
beat_bytes, 16, bytes per data beat (power of 2, ≥16)
max_bytes, 512, largest command size (power of 2, multiple of beat_bytes, ≤ page_bytes)
page_bytes, 4096, page size; max_bytes boundaries divide it
tag_width, 5, command tag width
ctxt_width, 10, context width
fifo_depth, 8, command FIFO entries (power of 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
i_cfg_max_sel  in  2  0=128B, 1=256B, 2=512B, 3=max_bytes; sampled at request accept
i_req_v  in  1  request valid
o_req_r  out  1  request ready
i_req_ea  in  ea_width  start EA
i_req_tag  in  tag_width  tag
i_req_ctxt  in  ctxt_width  context
i_data_v  in  1  upstream beat valid
o_data_r  out  1  upstream beat ready
i_data_e  in  1  last beat of request
i_data_c  in  log2(beat_bytes)  byte count of last beat; 0 = beat_bytes
o_dn_data_v  out  1  downstream beat valid
i_dn_data_r  in  1  downstream ready
o_dn_cmd_e  out  1  beat closes a command
o_dn_req_e  out  1  beat closes the request
o_cmd_v  out  1  command valid (FIFO head)
i_cmd_r  in  1  command pop
o_cmd_ea  out  ea_width  command EA
o_cmd_tsize  out  13  command bytes, 1..max_bytes
o_cmd_tag  out  tag_width  tag
o_cmd_ctxt  out  ctxt_width  context
o_cmd_last  out  1  final command of request
o_req_err  out  1  one-cycle pulse: EA not beat-aligned
o_cmd_used  out  log2(fifo_depth)+1  FIFO occupancy

Behaviour:
- Reset: FSM=IDLE; o_req_r=1 (registered IDLE decode); all other outputs 0; FIFO empty; counters cleared. Reset mid-stream discards the partial command and all queued commands.
- FSM IDLE: o_req_r=1. On i_req_v, latch ea (low log2(beat_bytes) bits forced to 0), tag, ctxt and size = f(i_cfg_max_sel). Set cmd_ea=ea, len=0, go to STREAM. If any low bits were nonzero, pulse o_req_err the next cycle; the request still proceeds.
- STREAM: o_req_r=0. Define go = i_data_v & i_dn_data_r & ~fifo_full.
  - o_data_r = i_dn_data_r & ~fifo_full.
  - o_dn_data_v = i_data_v & ~fifo_full.
  - o_dn_* markers are combinational and valid with o_dn_data_v.
- Beat bytes b: beat_bytes for a non-last beat (i_data_c ignored); {i_data_c==0, i_data_c} for the last beat.
- cmd_end = i_data_e | ((cmd_ea + len + beat_bytes) mod size == 0). Page crossing is implied because size divides page_bytes.
- On go & ~cmd_end: len += beat_bytes.
- On go & cmd_end: push {cmd_ea, len+b, tag, ctxt, i_data_e} into the FIFO, then cmd_ea += len+b and len=0. If i_data_e, go to IDLE.
- Latency: a command is visible on o_cmd_v one cycle after its closing beat is accepted. A new request can be accepted the cycle after the last beat.
- fifo_full = used == fifo_depth. A push and a pop in the same cycle with the FIFO full is not allowed, because push is gated by ~fifo_full.
- len is 13 bits and never exceeds max_bytes. The EA adder wraps modulo 2^ea_width without error.
- i_data_v while in IDLE: o_data_r=0 and the beat is held upstream.
- i_cfg_max_sel changes mid-request have no effect until the next request.

Decomposition:
- Package capi_putn_pkg holds: size-select encoding constants (SEL_128..SEL_MAX), the FSM state enum, the tsize width (13), and a command-entry struct {ea, tsize, tag, ctxt, last}.
- One sub-module: the existing nvme_fifo (width = ea_width+13+tag_width+ctxt_width+1, words = fifo_depth) as the command queue.

Test Plan:
- ea=0x1000, sel=2, 4 beats, last c=0 -> one command: ea 0x1000, tsize 64, last=1; o_dn_cmd_e only on beat 4.
- ea=0x11F0, sel=2, 3 beats, last c=8 -> command ea 0x11F0 tsize 16 last=0, then command ea 0x1200 tsize 24 last=1.
- sel=0, ea=0x2000, 20 full beats -> commands (0x2000,128), (0x2080,128), (0x2100,64,last).
- sel=3 with max_bytes=4096, ea=0x3FF0, 2 beats -> (0x3FF0,16), (0x4000,16,last); confirms page split.
- fifo_depth=4, i_cmd_r=0, five 1-beat requests -> o_data_r drops after the 4th push and o_cmd_used=4; raise i_cmd_r -> 5th accepted, five commands in order with no loss.
- ea=0x1004 -> o_req_err pulses once, command ea 0x1000. Reset asserted mid-stream -> o_cmd_v=0, o_cmd_used=0, o_req_r=1 after release.
